// File: rtl/cpu_phase_pkg.sv
// Shared constants and the wrap-aware window compare for cpu_phase_gen.
package cpu_phase_pkg;

  localparam int unsigned PERIOD_DEF    = 24;
  localparam int unsigned LOCK_STAB_MAX = 3;

  // A start greater than end describes a window that wraps through phase 0.
  function automatic logic in_window(input int unsigned ph,
                                     input int unsigned win_start,
                                     input int unsigned win_end);
    if (win_start <= win_end) begin
      return (ph >= win_start) && (ph <= win_end);
    end
    return (ph >= win_start) || (ph <= win_end);
  endfunction

endpackage

// File: rtl/cpu_phase_gen_if.sv
// CPU strobe pins, window programming and phase/lock status of cpu_phase_gen.
interface cpu_phase_gen_if
  import cpu_phase_pkg::*;
#(
  parameter int unsigned NCH = 2,
  parameter int unsigned PW  = $clog2(PERIOD_DEF),
  parameter int unsigned MW  = 8
);

  logic              cpu_oe_n;
  logic              cpu_we_n;
  logic [NCH-1:0]    ch_en;
  logic [NCH*PW-1:0] win_start;
  logic [NCH*PW-1:0] win_end;
  logic [NCH-1:0]    cpu_ce;
  logic [PW-1:0]     phase;
  logic [MW-1:0]     meas_period;
  logic              locked;
  logic [7:0]        sync_cnt;

  modport master (
    output cpu_oe_n, cpu_we_n, ch_en, win_start, win_end,
    input  cpu_ce, phase, meas_period, locked, sync_cnt
  );

  modport slave (
    input  cpu_oe_n, cpu_we_n, ch_en, win_start, win_end,
    output cpu_ce, phase, meas_period, locked, sync_cnt
  );

endinterface

// File: rtl/strobe_edge_sync.sv
// Synchronises an async strobe and flags assertion after two idle samples.
module strobe_edge_sync #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic strobe,
  output logic strobe_edge
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   h1_q;
  logic                   h2_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      h1_q   <= 1'b0;
      h2_q   <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], strobe};
      h1_q   <= sync_q[SYNC_STAGES-1];
      h2_q   <= h1_q;
    end
  end

  // Two idle history samples reject a single-cycle dropout mid-strobe.
  assign strobe_edge = sync_q[SYNC_STAGES-1] & ~h1_q & ~h2_q;

endmodule

// File: rtl/cpu_phase_gen.sv
// Bus-cycle phase tracker with per-channel CE windows and period lock detect.
// Define CPU_PHASE_WE_SYNC_EN to also resync on CPU write strobes.
module cpu_phase_gen
  import cpu_phase_pkg::*;
#(
  parameter int unsigned NCH         = 2,
  parameter int unsigned PERIOD      = PERIOD_DEF,
  parameter int unsigned PW          = $clog2(PERIOD),
  parameter int unsigned MW          = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned LOCK_TOL    = 1
) (
  input logic            clk,
  input logic            rst,
  cpu_phase_gen_if.slave bus
);

  localparam logic [MW-1:0] PcntMax   = '1;
  localparam logic [PW-1:0] PhaseLast = PW'(PERIOD - 1);
  localparam logic [1:0]    StabMax   = 2'(LOCK_STAB_MAX);
  localparam int unsigned   StallCnt  = 2 * PERIOD;

  logic           oe_edge;
  logic           sync_edge;
  logic [PW-1:0]  phase_q;
  logic [NCH-1:0] pst_q;
  logic [NCH-1:0] in_win;
  logic [MW-1:0]  pcnt_q;
  logic [MW-1:0]  meas_q;
  logic [MW-1:0]  meas_new;
  logic [MW-1:0]  meas_diff;
  logic           meas_agree;
  logic [7:0]     sync_cnt_q;
  logic [1:0]     stab_q;
  logic           seen_q;

  strobe_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_oe_sync (
    .clk        (clk),
    .rst        (rst),
    .strobe     (~bus.cpu_oe_n),
    .strobe_edge(oe_edge)
  );

`ifdef CPU_PHASE_WE_SYNC_EN
  logic we_edge;

  strobe_edge_sync #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_we_sync (
    .clk        (clk),
    .rst        (rst),
    .strobe     (~bus.cpu_we_n),
    .strobe_edge(we_edge)
  );

  assign sync_edge = oe_edge | we_edge;
`else
  assign sync_edge = oe_edge;
`endif

  always_comb begin
    in_win = '0;
    for (int c = 0; c < NCH; c++) begin
      in_win[c] = in_window(32'(phase_q), 32'(bus.win_start[c*PW +: PW]),
                            32'(bus.win_end[c*PW +: PW]));
    end
  end

  // A saturated count stays saturated so a stalled bus never looks agreeable.
  always_comb begin
    meas_new   = (pcnt_q == PcntMax) ? PcntMax : pcnt_q + MW'(1);
    meas_diff  = (meas_new >= meas_q) ? meas_new - meas_q : meas_q - meas_new;
    meas_agree = (meas_new != PcntMax) && (meas_q != PcntMax) &&
                 (32'(meas_diff) <= LOCK_TOL);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q    <= '0;
      pst_q      <= '0;
      pcnt_q     <= '0;
      meas_q     <= '0;
      sync_cnt_q <= '0;
      stab_q     <= '0;
      seen_q     <= 1'b0;
    end else begin
      pst_q <= in_win & bus.ch_en;
      if (sync_edge) begin
        phase_q    <= '0;
        pcnt_q     <= '0;
        meas_q     <= meas_new;
        sync_cnt_q <= sync_cnt_q + 8'd1;
        seen_q     <= 1'b1;
        if (seen_q) begin
          if (!meas_agree) begin
            stab_q <= '0;
          end else if (stab_q != StabMax) begin
            stab_q <= stab_q + 2'd1;
          end
        end
      end else begin
        phase_q <= (phase_q >= PhaseLast) ? '0 : phase_q + PW'(1);
        if (pcnt_q != PcntMax) begin
          pcnt_q <= pcnt_q + MW'(1);
        end
        if (32'(pcnt_q) >= StallCnt) begin
          stab_q <= '0;
        end
      end
    end
  end

  // Strobe term is deliberately combinational so CE spans the whole access.
  assign bus.cpu_ce      = pst_q | (bus.ch_en & {NCH{~bus.cpu_oe_n | ~bus.cpu_we_n}});
  assign bus.phase       = phase_q;
  assign bus.meas_period = meas_q;
  assign bus.locked      = (stab_q == StabMax);
  assign bus.sync_cnt    = sync_cnt_q;

endmodule

// File: tb/tb_cpu_phase_gen.sv
// Scoreboard bench for cpu_phase_gen: free-run, resync, lock, glitch, stall, channels, WE.
module tb_cpu_phase_gen;
  import cpu_phase_pkg::*;

  localparam int unsigned NCH = 2;
  localparam int unsigned PW  = 5;
  localparam int unsigned MW  = 8;

  typedef struct {
    string       tag;
    int unsigned exp;
  } sb_item_t;

  logic        mclk8x = 1'b0;
  logic        rst;
  int unsigned n_checks = 0;
  int unsigned n_pass = 0;
  sb_item_t    sb_q[$];

  always #5 mclk8x = ~mclk8x;

  cpu_phase_gen_if #(.NCH(NCH), .PW(PW), .MW(MW)) bus ();

  cpu_phase_gen #(
    .NCH        (NCH),
    .PERIOD     (PERIOD_DEF),
    .PW         (PW),
    .MW         (MW),
    .SYNC_STAGES(2),
    .LOCK_TOL   (1)
  ) dut (
    .clk(mclk8x),
    .rst(rst),
    .bus(bus)
  );

  task automatic check_eq(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: observed %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic sb_push(input string tag, input int unsigned exp);
    sb_item_t it;
    it.tag = tag;
    it.exp = exp;
    sb_q.push_back(it);
  endtask

  task automatic sb_pop(input int unsigned obs);
    sb_item_t it;
    if (sb_q.size() == 0) begin
      n_checks++;
      $display("FAIL sb_empty: observed %0d, expected an entry", obs);
      return;
    end
    it = sb_q.pop_front();
    check_eq(it.tag, obs, it.exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge mclk8x);
    #1;
  endtask

  task automatic sb_push_win(input int unsigned ph, input int unsigned ce0,
                             input int unsigned ce1);
    sb_push("phase", ph);
    sb_push("cpu_ce0", ce0);
    sb_push("cpu_ce1", ce1);
  endtask

  task automatic sb_pop_win();
    sb_pop(32'(bus.phase));
    sb_pop(32'(bus.cpu_ce[0]));
    sb_pop(32'(bus.cpu_ce[1]));
  endtask

  task automatic sb_push_status(input int unsigned meas, input int unsigned lck,
                                input int unsigned syn);
    sb_push("meas_period", meas);
    sb_push("locked", lck);
    sb_push("sync_cnt", syn);
  endtask

  task automatic sb_pop_status();
    sb_pop(32'(bus.meas_period));
    sb_pop(32'(bus.locked));
    sb_pop(32'(bus.sync_cnt));
  endtask

  // Strobe low for low_cyc clocks; returns total_cyc clocks after the fall.
  task automatic oe_pulse(input int low_cyc, input int total_cyc);
    bus.cpu_oe_n = 1'b0;
    cyc(low_cyc);
    bus.cpu_oe_n = 1'b1;
    cyc(total_cyc - low_cyc);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst           = 1'b1;
    bus.cpu_oe_n  = 1'b1;
    bus.cpu_we_n  = 1'b1;
    bus.ch_en     = 2'b11;
    bus.win_start = {5'd8, 5'd16};
    bus.win_end   = {5'd8, 5'd2};

    // Reset: all outputs low.
    for (int i = 0; i < 3; i++) begin
      sb_push_win(0, 0, 0);
      sb_push_status(0, 0, 0);
      cyc(1);
      sb_pop_win();
      sb_pop_status();
    end
    rst = 1'b0;

    // Free run: ch0 16..2 shows at 17..3, ch1 single phase 8 shows at 9.
    for (int k = 1; k <= 48; k++) begin
      int unsigned ph;
      ph = k % PERIOD_DEF;
      sb_push_win(ph, (ph >= 17 || ph <= 3) ? 1 : 0, (ph == 9) ? 1 : 0);
      cyc(1);
      sb_pop_win();
    end

    // Resync from phase 10: still counting after 2 clocks, zero after 3.
    cyc(10);
    bus.cpu_oe_n = 1'b0;
    sb_push("pre_resync_phase", 12);
    sb_push("pre_resync_sync_cnt", 0);
    cyc(2);
    sb_pop(32'(bus.phase));
    sb_pop(32'(bus.sync_cnt));
    sb_push("resync_phase", 0);
    sb_push_status(61, 0, 1);
    cyc(1);
    sb_pop(32'(bus.phase));
    sb_pop_status();
    bus.cpu_oe_n = 1'b1;

    for (int j = 1; j <= 21; j++) begin
      sb_push_win(j, (j >= 17 || j <= 3) ? 1 : 0, (j == 9) ? 1 : 0);
      cyc(1);
      sb_pop_win();
    end

    // Lock: five 24-clock bus cycles.
    for (int p = 1; p <= 5; p++) begin
      sb_push("lock_phase", 21);
      sb_push_status(24, (p >= 4) ? 1 : 0, 1 + p);
      oe_pulse(4, 24);
      sb_pop(32'(bus.phase));
      sb_pop_status();
    end

    // One long cycle breaks lock.
    cyc(6);
    sb_push_status(30, 0, 7);
    oe_pulse(4, 24);
    sb_pop_status();

    // Single-clock dropout mid-strobe must not resync.
    bus.cpu_oe_n = 1'b0;
    cyc(6);
    bus.cpu_oe_n = 1'b1;
    cyc(1);
    bus.cpu_oe_n = 1'b0;
    sb_push("glitch_phase", 9);
    sb_push("glitch_sync_cnt", 8);
    cyc(5);
    sb_pop(32'(bus.phase));
    sb_pop(32'(bus.sync_cnt));
    bus.cpu_oe_n = 1'b1;
    sb_push_status(24, 0, 8);
    cyc(12);
    sb_pop_status();

    // Relock, then stall the bus.
    for (int p = 1; p <= 3; p++) begin
      sb_push_status(24, (p == 3) ? 1 : 0, 8 + p);
      oe_pulse(4, 24);
      sb_pop_status();
    end
    sb_push("stall_locked_45", 1);
    cyc(24);
    sb_pop(32'(bus.locked));
    sb_push("stall_locked_52", 0);
    cyc(7);
    sb_pop(32'(bus.locked));
    cyc(250);
    sb_push_status(255, 0, 12);
    oe_pulse(4, 24);
    sb_pop_status();

    // Channels: ch0 4..6, ch1 20..1 disabled.
    rst           = 1'b1;
    bus.ch_en     = 2'b01;
    bus.win_start = {5'd20, 5'd4};
    bus.win_end   = {5'd1, 5'd6};
    sb_push_status(0, 0, 0);
    cyc(2);
    sb_pop_status();
    rst = 1'b0;
    for (int k = 1; k <= 48; k++) begin
      int unsigned ph;
      ph = k % PERIOD_DEF;
      sb_push_win(ph, (ph >= 5 && ph <= 7) ? 1 : 0, 0);
      cyc(1);
      sb_pop_win();
    end

    // Strobe reaches CE with no clock in between.
    bus.cpu_oe_n = 1'b0;
    sb_push("oe_direct_ce0", 1);
    sb_push("oe_direct_ce1", 0);
    #1;
    sb_pop(32'(bus.cpu_ce[0]));
    sb_pop(32'(bus.cpu_ce[1]));
    bus.cpu_oe_n = 1'b1;
    #1;

    // Write strobe at phase 12.
    cyc(12);
    bus.cpu_we_n = 1'b0;
    sb_push("we_direct_ce0", 1);
    #1;
    sb_pop(32'(bus.cpu_ce[0]));
`ifdef CPU_PHASE_WE_SYNC_EN
    sb_push("we_phase", 0);
    sb_push("we_sync_cnt", 1);
`else
    sb_push("we_phase", 15);
    sb_push("we_sync_cnt", 0);
`endif
    cyc(3);
    sb_pop(32'(bus.phase));
    sb_pop(32'(bus.sync_cnt));
    bus.cpu_we_n = 1'b1;
`ifdef CPU_PHASE_WE_SYNC_EN
    sb_push("we_after_phase", 4);
`else
    sb_push("we_after_phase", 19);
`endif
    cyc(4);
    sb_pop(32'(bus.phase));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_phase_gen.md
Name: cpu_phase_gen

Overview:
- Parametrised successor to the top-level cpu_ce phase logic. Runs on the 8x PLL clock and tracks the console bus cycle by resynchronising a phase counter on each CPU read-strobe assertion.
- Generates NCH independent, runtime-programmable access windows, e.g. one per PSRAM chip.
- Measures the real bus-cycle period and reports lock status.
- Sits in top between the PLL/CPU pins and the turbo_ed core's per-RAM ce inputs.

Parameters:
- NCH, 2, number of window channels.
- PERIOD, 24, nominal phase count per bus cycle; phase wraps at PERIOD-1.
- PW, $clog2(PERIOD), phase width.
- MW, 8, measured-period counter width.
- SYNC_STAGES, 2, metastability flops on async strobes (min 2).
- LOCK_TOL, 1, allowed ± difference between consecutive period measurements.

Ports:
- clk  in  1  8x master clock (PLL c0).
- rst  in  1  synchronous reset, active-high.
- cpu_oe_n  in  1  async CPU read strobe, active-low.
- cpu_we_n  in  1  async CPU write strobe, active-low.
- ch_en  in  NCH  per-channel enable.
- win_start  in  NCH*PW  per-channel window start phase, packed, ch0 in LSBs.
- win_end  in  NCH*PW  per-channel window end phase, inclusive.
- cpu_ce  out  NCH  chip-enable per channel.
- phase  out  PW  current phase.
- meas_period  out  MW  last measured bus-cycle length in clk cycles.
- locked  out  1  period stable.
- sync_cnt  out  8  count of resync events, wrapping.

Behaviour:
- Strobe sync: oe_a = !cpu_oe_n runs through SYNC_STAGES flops into oe_s, plus 2 history flops h1, h2.
- oe_edge = oe_s & !h1 & !h2, i.e. newest sample asserted after 2 deasserted samples; this rejects 1-cycle dropouts.
- Phase counter:
  - oe_edge gives phase <= 0.
  - Otherwise phase <= (phase >= PERIOD-1) ? 0 : phase+1.
  - An out-of-range value (>= PERIOD) also wraps to 0.
- Window decode, per channel c, on the current phase:
  - If start <= end: in_win = start <= phase <= end.
  - If start > end (wrap): in_win = phase >= start | phase <= end.
  - start == end gives a single phase.
- pst[c] <= in_win & ch_en[c], registered. Latency: one clk after phase reaches start.
- cpu_ce[c] = pst[c] | (ch_en[c] & (!cpu_oe_n | !cpu_we_n)).
  - Combinational from the raw pins, deliberately zero-latency so PSRAM CE covers the whole strobe.
  - ch_en[c] = 0 forces cpu_ce[c] = 0.
- Period measurement:
  - pcnt increments every clk and saturates at 2^MW-1.
  - On oe_edge: meas_period <= pcnt+1, pcnt <= 0, sync_cnt <= sync_cnt+1.
  - The first edge after reset updates meas_period but is not used for lock.
- Lock:
  - On each oe_edge after the first, compare the new measurement with the previous one.
  - If |diff| <= LOCK_TOL and neither measurement is saturated, stab <= stab+1 (saturating at 3); else stab <= 0.
  - locked = (stab == 3), i.e. 3 consecutive agreeing measurements.
  - locked drops when pcnt reaches 2*PERIOD with no edge (bus stalled), or on any disagreeing measurement.
- Simultaneous events: oe_edge has priority over wrap. On the same cycle as phase rollover, phase goes to 0 and pcnt restarts.
- Reset values: phase=0, pst=0 (so cpu_ce follows only the strobes), pcnt=0, meas_period=0, locked=0, stab=0, sync_cnt=0, sync and history flops=0.
- Mid-operation reset: all state clears on the next clk.
- Window registers are not latched; window input changes take effect on the next phase evaluation.

Optional Feature:
- Macro: CPU_PHASE_WE_SYNC_EN.
- Defined:
  - A second sync chain on !cpu_we_n produces we_edge with the same 2-idle-sample rule.
  - Phase resync triggers on oe_edge | we_edge.
  - Period measurement and sync_cnt count either edge.
  - Simultaneous edges count once.
- Undefined: cpu_we_n feeds only the combinational cpu_ce term; no we sync flops exist.

Decomposition:
- Package cpu_phase_pkg holds:
  - the default constants PERIOD_DEF=24 and LOCK_STAB_MAX=3;
  - the function in_window(phase, start, end) implementing the wrap-aware compare, shared by all channels.
- Sub-module strobe_edge_sync holds the sync chain, the 2 history flops and the edge output. It is instantiated once for oe and once for we when CPU_PHASE_WE_SYNC_EN is defined.

Test Plan:
- Reset and free-run:
  - Stimulus: rst held 3 cycles, strobes idle, window0 16..2.
  - Required: all outputs 0 during reset; afterwards phase counts 0..23 and wraps.
  - Required: cpu_ce[0] is high during phases 17..23 and 0..3 (one-cycle window latency).
- Resync:
  - Stimulus: cpu_oe_n falls at phase 10.
  - Required: phase=0 exactly SYNC_STAGES+1 clk later, sync_cnt increments by 1.
  - Required: window timing restarts from that point.
- Lock:
  - Stimulus: cpu_oe_n pulses every 24 clk, 5 times.
  - Required: meas_period=24, locked=1 after the 4th edge.
  - Stimulus: then one pulse at 30 clk.
  - Required: locked=0.
- Glitch and stall:
  - Stimulus: a 1-clk cpu_oe_n high dropout mid-strobe.
  - Required: no resync.
  - Stimulus: no strobes for 48 clk while locked.
  - Required: locked=0, pcnt saturates at 255.
- Channels:
  - Stimulus: ch0 window 4..6, ch1 window 20..1, ch_en=2'b01, strobes idle.
  - Required: cpu_ce[1]=0 always; cpu_ce[0] high during phases 5..7 only.
  - Stimulus: cpu_oe_n low.
  - Required: cpu_ce[0]=1 immediately.
- WE sync (with CPU_PHASE_WE_SYNC_EN defined):
  - Stimulus: cpu_we_n falls at phase 12.
  - Required: phase resyncs to 0 and sync_cnt increments.
  - Without the macro, the same stimulus does not resync.
